// File: rtl/booth_mult_arbiter.sv
// Round-robin front end that shares one pipelined Booth multiplier between NREQ requesters,
// tracking per-requester outstanding operations and routing each product back to its owner.
module booth_mult_arbiter #(
   parameter int WIDTH   = 32,
   parameter int NREQ    = 4,
   parameter int LATENCY = 7,
   parameter int MAX_OUT = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*WIDTH-1:0]   req_mcand,
   input  logic [NREQ*WIDTH-1:0]   req_mult,
   input  logic [NREQ*2-1:0]       req_mode,
   output logic [NREQ-1:0]         rsp_valid,
   output logic [2*WIDTH-1:0]      rsp_product,
   output logic [WIDTH-1:0]        mul_multiplicand,
   output logic [WIDTH-1:0]        mul_multiplier,
   output logic [1:0]              mul_sign_mode,
   input  logic [2*WIDTH-1:0]      mul_product,
   output logic                    busy
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW   = $clog2(MAX_OUT + 1);

   logic [IDXW-1:0]          r_last;
   logic [NREQ-1:0][CW-1:0]  r_count;
   logic [LATENCY:0]         r_tag_v;
   logic [IDXW-1:0]          r_tag_idx [0:LATENCY];
   logic [WIDTH-1:0]         r_mcand;
   logic [WIDTH-1:0]         r_mult;
   logic [1:0]               r_mode;
   logic [NREQ-1:0]          r_rsp_valid;
   logic [2*WIDTH-1:0]       r_rsp_product;

   logic [NREQ-1:0]          w_elig;
   logic [NREQ-1:0]          w_grant;
   logic [IDXW-1:0]          w_gnt_idx;
   logic [IDXW-1:0]          w_cand;
   logic                     w_found;
   logic                     w_hs;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         w_elig[i] = req_valid[i] && (r_count[i] < CW'(MAX_OUT));
      end
   end

   // Handshake: requester i transfers in a cycle where req_valid[i] and req_ready[i] are both
   // high. req_ready never depends on req_ready itself and is held low while rst_n is low.
   always_comb begin
      w_grant   = '0;
      w_gnt_idx = '0;
      w_cand    = '0;
      w_found   = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         w_cand = IDXW'((int'(r_last) + k) % NREQ);
         if (rst_n && !w_found && w_elig[w_cand]) begin
            w_found            = 1'b1;
            w_gnt_idx          = w_cand;
            w_grant[w_cand]    = 1'b1;
         end
      end
   end

   assign req_ready = w_grant;
   assign w_hs      = |(req_valid & w_grant);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last        <= IDXW'(NREQ - 1);
         r_count       <= '0;
         r_tag_v       <= '0;
         r_mcand       <= '0;
         r_mult        <= '0;
         r_mode        <= '0;
         r_rsp_valid   <= '0;
         r_rsp_product <= '0;
         for (int k = 0; k <= LATENCY; k++) begin
            r_tag_idx[k] <= '0;
         end
      end else begin
         if (w_hs) begin
            r_last  <= w_gnt_idx;
            r_mcand <= req_mcand[w_gnt_idx*WIDTH +: WIDTH];
            r_mult  <= req_mult[w_gnt_idx*WIDTH +: WIDTH];
            r_mode  <= req_mode[w_gnt_idx*2 +: 2];
         end

         // Stage 0 lines up with the mul_* registers, so the last stage lines up with mul_product.
         r_tag_v[0]   <= w_hs;
         r_tag_idx[0] <= w_gnt_idx;
         for (int k = 1; k <= LATENCY; k++) begin
            r_tag_v[k]   <= r_tag_v[k-1];
            r_tag_idx[k] <= r_tag_idx[k-1];
         end

         r_rsp_valid <= '0;
         if (r_tag_v[LATENCY]) begin
            r_rsp_valid[r_tag_idx[LATENCY]] <= 1'b1;
            r_rsp_product                   <= mul_product;
         end

         for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i] && !r_rsp_valid[i] && (r_count[i] < CW'(MAX_OUT))) begin
               r_count[i] <= r_count[i] + CW'(1);
            end else if (r_rsp_valid[i] && !w_grant[i] && (r_count[i] != '0)) begin
               r_count[i] <= r_count[i] - CW'(1);
            end
         end
      end
   end

   assign mul_multiplicand = r_mcand;
   assign mul_multiplier   = r_mult;
   assign mul_sign_mode    = r_mode;
   assign rsp_valid        = r_rsp_valid;
   assign rsp_product      = r_rsp_product;
   assign busy             = (|r_tag_v) | (|r_rsp_valid);

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Randomized and directed bench for booth_mult_arbiter: a transaction-level model predicts
// grants, operand registers, responses and busy; a behavioural multiplier closes the loop.
module tb_booth_mult_arbiter;

   localparam int W = 32;
   localparam int N = 4;
   localparam int L = 7;
   localparam int M = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [N-1:0]       req_valid;
   logic [N-1:0]       req_ready;
   logic [N*W-1:0]     req_mcand;
   logic [N*W-1:0]     req_mult;
   logic [N*2-1:0]     req_mode;
   logic [N-1:0]       rsp_valid;
   logic [2*W-1:0]     rsp_product;
   logic [W-1:0]       mul_multiplicand;
   logic [W-1:0]       mul_multiplier;
   logic [1:0]         mul_sign_mode;
   logic [2*W-1:0]     mul_product;
   logic               busy;

   always #5 clk = ~clk;

   booth_mult_arbiter #(.WIDTH(W), .NREQ(N), .LATENCY(L), .MAX_OUT(M)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_mcand        (req_mcand),
      .req_mult         (req_mult),
      .req_mode         (req_mode),
      .rsp_valid        (rsp_valid),
      .rsp_product      (rsp_product),
      .mul_multiplicand (mul_multiplicand),
      .mul_multiplier   (mul_multiplier),
      .mul_sign_mode    (mul_sign_mode),
      .mul_product      (mul_product),
      .busy             (busy)
   );

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [1:0] md);
      logic [2*W-1:0] ea;
      logic [2*W-1:0] eb;
      ea = md[1] ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
      eb = md[0] ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
      return ea * eb;
   endfunction

   // Multiplier stand-in: L clock edges from the mul_* registers to mul_product.
   logic [2*W-1:0] mul_pipe [0:L-1];
   always @(posedge clk) begin
      mul_pipe[0] <= ref_mul(mul_multiplicand, mul_multiplier, mul_sign_mode);
      for (int k = 1; k < L; k++) begin
         mul_pipe[k] <= mul_pipe[k-1];
      end
   end
   assign mul_product = mul_pipe[L-1];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Scoreboard: one entry per accepted operation, oldest first.
   logic [2*W-1:0] exp_q[$];
   int             exp_idx_q[$];
   int             exp_issue_q[$];

   int             m_last = N - 1;
   logic [W-1:0]   m_mcand = '0;
   logic [W-1:0]   m_mult = '0;
   logic [1:0]     m_mode = '0;
   logic [2*W-1:0] m_last_prod = '0;
   int             n_hs = 0;
   int             n_dropped = 0;
   int             n_obs_rsp = 0;
   int             last_hs_cyc = 0;
   int             last_rsp_cyc = -1;
   logic [N-1:0]   last_rsp_vld = '0;
   logic [2*W-1:0] last_rsp_prod = '0;
   int             grant_log[$];
   logic [N-1:0]   rdy_hist[$];

   task automatic model_cycle();
      int           cnt [N];
      int           g;
      int           cand;
      logic [N-1:0] e_rdy;
      logic [N-1:0] e_vld;
      if (!rst_n) begin
         check_eq("ready_in_reset", 64'(req_ready), 64'(0));
         n_dropped += exp_q.size();
         exp_q.delete();
         exp_idx_q.delete();
         exp_issue_q.delete();
         m_last      = N - 1;
         m_mcand     = '0;
         m_mult      = '0;
         m_mode      = '0;
         m_last_prod = '0;
         rdy_hist.push_back(req_ready);
         return;
      end
      for (int i = 0; i < N; i++) cnt[i] = 0;
      foreach (exp_idx_q[j]) cnt[exp_idx_q[j]]++;

      check_eq("busy", 64'(busy), 64'(exp_q.size() > 0 && exp_issue_q[0] < cyc));
      check_eq("mul_mcand", 64'(mul_multiplicand), 64'(m_mcand));
      check_eq("mul_mult", 64'(mul_multiplier), 64'(m_mult));
      check_eq("mul_mode", 64'(mul_sign_mode), 64'(m_mode));

      if (rsp_valid != '0) begin
         n_obs_rsp++;
         last_rsp_vld  = rsp_valid;
         last_rsp_prod = rsp_product;
         last_rsp_cyc  = cyc;
      end
      if (exp_q.size() > 0 && exp_issue_q[0] + L + 2 == cyc) begin
         e_vld = '0;
         e_vld[exp_idx_q[0]] = 1'b1;
         check_eq("rsp_valid", 64'(rsp_valid), 64'(e_vld));
         check_eq("rsp_product", rsp_product, exp_q[0]);
         m_last_prod = exp_q.pop_front();
         void'(exp_idx_q.pop_front());
         void'(exp_issue_q.pop_front());
      end else begin
         check_eq("rsp_valid_idle", 64'(rsp_valid), 64'(0));
         check_eq("rsp_product_hold", rsp_product, m_last_prod);
      end

      e_rdy = '0;
      g = -1;
      for (int k = 1; k <= N; k++) begin
         cand = (m_last + k) % N;
         if (g < 0 && req_valid[cand] && cnt[cand] < M) g = cand;
      end
      if (g >= 0) e_rdy[g] = 1'b1;
      check_eq("req_ready", 64'(req_ready), 64'(e_rdy));
      rdy_hist.push_back(req_ready);
      for (int i = 0; i < N; i++) begin
         if (req_ready[i]) grant_log.push_back(i);
      end

      if (g >= 0) begin
         exp_q.push_back(ref_mul(req_mcand[g*W +: W], req_mult[g*W +: W], req_mode[g*2 +: 2]));
         exp_idx_q.push_back(g);
         exp_issue_q.push_back(cyc);
         m_last      = g;
         m_mcand     = req_mcand[g*W +: W];
         m_mult      = req_mult[g*W +: W];
         m_mode      = req_mode[g*2 +: 2];
         n_hs++;
         last_hs_cyc = cyc;
      end
   endtask

   task automatic drive_cycle(input logic rst_v, input logic [N-1:0] v, input logic [N*W-1:0] mc,
                              input logic [N*W-1:0] ml, input logic [2*N-1:0] md);
      rst_n     = rst_v;
      req_valid = v;
      req_mcand = mc;
      req_mult  = ml;
      req_mode  = md;
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive_one(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] md);
      logic [N*W-1:0] mc;
      logic [N*W-1:0] ml;
      logic [2*N-1:0] mo;
      logic [N-1:0]   v;
      mc = '0; ml = '0; mo = '0; v = '0;
      mc[r*W +: W] = a;
      ml[r*W +: W] = b;
      mo[r*2 +: 2] = md;
      v[r] = 1'b1;
      drive_cycle(1'b1, v, mc, ml, mo);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b1, '0, '0, '0, '0);
   endtask

   function automatic logic [W-1:0] rand_op();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic drive_random(input logic [N-1:0] v);
      logic [N*W-1:0] mc;
      logic [N*W-1:0] ml;
      logic [2*N-1:0] mo;
      for (int i = 0; i < N; i++) begin
         mc[i*W +: W] = rand_op();
         ml[i*W +: W] = rand_op();
         mo[i*2 +: 2] = 2'($urandom_range(0, 3));
      end
      drive_cycle(1'b1, v, mc, ml, mo);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int g0;
      int h0;
      int s0;
      int o0;
      int rstart;
      logic [N-1:0] v;

      rst_n = 1'b0; req_valid = '0; req_mcand = '0; req_mult = '0; req_mode = '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, '0, '0, '0);
      check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check_eq("rst_rsp_product", rsp_product, 64'(0));
      check_eq("rst_mul_mcand", 64'(mul_multiplicand), 64'(0));
      check_eq("rst_busy", 64'(busy), 64'(0));
      idle(2);

      // Signed x signed small operands on requester 0
      last_rsp_vld = '0;
      drive_one(0, 32'd3, 32'hFFFF_FFFB, 2'b11);
      idle(12);
      check_eq("s11_latency", 64'(last_rsp_cyc - last_hs_cyc), 64'(9));
      check_eq("s11_owner", 64'(last_rsp_vld), 64'(4'b0001));
      check_eq("s11_product", last_rsp_prod, 64'hFFFF_FFFF_FFFF_FFF1);

      last_rsp_vld = '0;
      drive_one(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
      idle(12);
      check_eq("u00_owner", 64'(last_rsp_vld), 64'(4'b0100));
      check_eq("u00_product", last_rsp_prod, 64'hFFFF_FFFE_0000_0001);

      last_rsp_vld = '0;
      drive_one(2, 32'hFFFF_FFFF, 32'd2, 2'b10);
      idle(12);
      check_eq("s10_owner", 64'(last_rsp_vld), 64'(4'b0100));
      check_eq("s10_product", last_rsp_prod, 64'hFFFF_FFFF_FFFF_FFFE);

      // All requesters valid straight out of reset
      drive_cycle(1'b0, '0, '0, '0, '0);
      g0 = grant_log.size();
      h0 = n_hs;
      for (int i = 0; i < 24; i++) drive_random('1);
      for (int j = 0; j < 8; j++) begin
         check_eq("rr_order", 64'(grant_log[g0 + j]), 64'(j % 4));
      end
      check_eq("rr_no_gaps", 64'(n_hs - h0), 64'(24));
      idle(12);

      // Single requester held valid hits the outstanding limit
      s0 = rdy_hist.size();
      for (int i = 0; i < 30; i++) drive_one(1, rand_op(), rand_op(), 2'($urandom_range(0, 3)));
      for (int j = 0; j <= 10; j++) begin
         check_eq("limit_ready1", 64'(rdy_hist[s0 + j][1]), 64'(j < 4 || j == 10));
      end
      idle(12);

      // Reset with operations in flight
      drive_one(0, rand_op(), rand_op(), 2'b11);
      drive_one(1, rand_op(), rand_op(), 2'b01);
      drive_one(2, rand_op(), rand_op(), 2'b10);
      o0 = n_obs_rsp;
      drive_cycle(1'b0, '0, '0, '0, '0);
      idle(12);
      check_eq("flush_no_rsp", 64'(n_obs_rsp - o0), 64'(0));
      check_eq("flush_busy", 64'(busy), 64'(0));
      drive_cycle(1'b1, 4'b1001, '1, '1, '1);
      check_eq("flush_grant_first", 64'(rdy_hist[rdy_hist.size() - 1]), 64'(4'b0001));
      drive_cycle(1'b1, 4'b1001, '1, '1, '1);
      check_eq("flush_grant_second", 64'(rdy_hist[rdy_hist.size() - 1]), 64'(4'b1000));
      idle(12);

      // Random traffic, sometimes concentrated on one requester to reach the limit
      rstart = n_hs;
      for (int c = 0; c < 4000 && (n_hs - rstart) < 1000; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            v = '0;
            v[$urandom_range(0, N - 1)] = 1'b1;
         end else begin
            for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 9) < 7);
         end
         drive_random(v);
      end
      check_eq("rand_ops_reached", 64'((n_hs - rstart) >= 1000), 64'(1));
      idle(15);
      check_eq("one_rsp_per_hs", 64'(n_obs_rsp), 64'(n_hs - n_dropped));
      check_eq("idle_busy", 64'(busy), 64'(0));
      check_eq("idle_sb_empty", 64'(exp_q.size()), 64'(0));
      for (int i = 0; i < N; i++) begin
         check_eq("idle_count", 64'(dut.r_count[i]), 64'(0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
